// File: rtl/hazard_response_pipe.sv
// -----------------------------------------------------------------------------
// hazard_response_pipe
//   Pipeline-register side of the hazard interface for the 5-stage MIPS core.
//   Holds the fetch PC, the IF/ID register and the ID/EX register, and obeys
//   the hazard unit's StallF/StallD/FlushE plus the branch-taken clear (PCSrcD).
//   Also counts stall and bubble cycles, and raises a sticky StallTimeout when
//   StallD stays high for more than MAX_STALL consecutive cycles.
//
// Ports
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   StallF / StallD / FlushE     hold PC / hold IF/ID / bubble into ID/EX
//   PCSrcD                       branch/jump taken in D: clear IF/ID (unless stalled)
//   PCNextF, InstrF, PCPlus4F    fetch-stage inputs
//   CtrlD, RD1D, RD2D, SignImmD,
//   RsD, RtD, RdD                decode-stage inputs captured into ID/EX
//   PCF                          current fetch PC
//   InstrD, PCPlus4D, ValidD     IF/ID contents
//   CtrlE, RD1E, RD2E, SignImmE,
//   RsE, RtE, RdE, ValidE        ID/EX contents
//   StallCount, BubbleCount      saturating event counters
//   StallTimeout                 sticky lockup flag, cleared only by reset
// -----------------------------------------------------------------------------
module hazard_response_pipe #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          CTRL_W    = 10,
  parameter int          MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              PCSrcD,
  input  logic [31:0]       PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       PCPlus4F,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       SignImmD,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       SignImmE,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic [15:0]       StallCount,
  output logic [15:0]       BubbleCount,
  output logic              StallTimeout
);

  // Run-length counter must be able to represent MAX_STALL+1 so it can
  // saturate just past the limit.
  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALLED = 2'd1,
    LOCKED  = 2'd2
  } wdState_t;

  wdState_t         stateReg, stateNext;
  logic [RUN_W-1:0] runLenReg;

  // PC register
  always_ff @(posedge clk) begin
    if (reset)        PCF <= PC_RESET;
    else if (!StallF) PCF <= PCNextF;
  end

  // IF/ID register: a stall wins over the branch clear, so a held
  // instruction is never lost while decode is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (PCSrcD) begin
        InstrD   <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else begin
        InstrD   <= InstrF;
        PCPlus4D <= PCPlus4F;
        ValidD   <= 1'b1;
      end
    end
  end

  // ID/EX register: never holds. A bubble zeroes the whole control bundle,
  // so RegWrite/MemWrite cannot fire for the flushed slot.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      CtrlE    <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      SignImmE <= '0;
      RsE      <= '0;
      RtE      <= '0;
      RdE      <= '0;
      ValidE   <= 1'b0;
    end else begin
      CtrlE    <= CtrlD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      SignImmE <= SignImmD;
      RsE      <= RsD;
      RtE      <= RtD;
      RdE      <= RdD;
      ValidE   <= ValidD;
    end
  end

  // Saturating statistics counters: index 0 counts StallD, index 1 FlushE.
  logic [1:0] statEvent;
  assign statEvent = {FlushE, StallD};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gStat
      logic [15:0] cntReg;
      always_ff @(posedge clk) begin
        if (reset)
          cntReg <= '0;
        else if (statEvent[gi] && (cntReg != 16'hFFFF))
          cntReg <= cntReg + 16'd1;
      end
    end
  endgenerate

  assign StallCount  = gStat[0].cntReg;
  assign BubbleCount = gStat[1].cntReg;

  // Consecutive-stall run length
  always_ff @(posedge clk) begin
    if (reset || !StallD)       runLenReg <= '0;
    else if (runLenReg != RUN_SAT) runLenReg <= runLenReg + RUN_W'(1);
  end

  // Watchdog FSM. A stalled edge that would push the run past MAX_STALL
  // (run already at MAX_STALL) locks the watchdog until reset.
  always_ff @(posedge clk) begin
    if (reset) stateReg <= RUN;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RUN: begin
        if (StallD) stateNext = (runLenReg >= RUN_MAX) ? LOCKED : STALLED;
      end
      STALLED: begin
        if (!StallD)                   stateNext = RUN;
        else if (runLenReg >= RUN_MAX) stateNext = LOCKED;
      end
      LOCKED:  stateNext = LOCKED;
      default: stateNext = RUN;
    endcase
  end

  assign StallTimeout = (stateReg == LOCKED);

endmodule

// File: tb/tb_hazard_response_pipe.sv
module tb_hazard_response_pipe;

  localparam int CTRL_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              StallF = 1'b0, StallD = 1'b0, FlushE = 1'b0, PCSrcD = 1'b0;
  logic [31:0]       PCNextF = '0, InstrF = '0, PCPlus4F = '0;
  logic [CTRL_W-1:0] CtrlD = '0;
  logic [31:0]       RD1D = '0, RD2D = '0, SignImmD = '0;
  logic [4:0]        RsD = '0, RtD = '0, RdD = '0;
  logic [31:0]       PCF, InstrD, PCPlus4D;
  logic              ValidD, ValidE;
  logic [CTRL_W-1:0] CtrlE;
  logic [31:0]       RD1E, RD2E, SignImmE;
  logic [4:0]        RsE, RtE, RdE;
  logic [15:0]       StallCount, BubbleCount;
  logic              StallTimeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_response_pipe #(
    .PC_RESET(32'h0000_0000), .CTRL_W(CTRL_W), .MAX_STALL(3)
  ) dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .PCSrcD(PCSrcD),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .ValidE(ValidE),
    .StallCount(StallCount), .BubbleCount(BubbleCount),
    .StallTimeout(StallTimeout)
  );

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; PCNextF = 32'h40;
    tick(); tick();
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL reset_pcf got=%h exp=%h", PCF, 32'h0); end
    total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL reset_validd got=%b exp=0", ValidD); end
    total++; if (ValidE !== 1'b0) begin bad++; $display("FAIL reset_valide got=%b exp=0", ValidE); end
    total++; if (StallCount !== 16'h0) begin bad++; $display("FAIL reset_stallcnt got=%h exp=0", StallCount); end
    total++; if (BubbleCount !== 16'h0) begin bad++; $display("FAIL reset_bubblecnt got=%h exp=0", BubbleCount); end
    total++; if (StallTimeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", StallTimeout); end
    reset = 1'b0;
    tick();
    total++; if (PCF !== 32'h40) begin bad++; $display("FAIL release_pcf got=%h exp=%h", PCF, 32'h40); end
    $display("test_reset: PCF=%h ValidD=%b ValidE=%b", PCF, ValidD, ValidE);
  endtask

  task automatic test_load_use();
    InstrF = 32'h8C08_0004; PCPlus4F = 32'h44; PCNextF = 32'h44;
    CtrlD = 10'h003; RD1D = 32'h11; RD2D = 32'h22; SignImmD = 32'h4;
    RsD = 5'd0; RtD = 5'd8; RdD = 5'd0;
    tick();
    total++; if (InstrD !== 32'h8C08_0004) begin bad++; $display("FAIL lw_instrd got=%h exp=%h", InstrD, 32'h8C08_0004); end
    total++; if (CtrlE !== 10'h003) begin bad++; $display("FAIL lw_ctrle got=%h exp=%h", CtrlE, 10'h003); end
    total++; if (RD1E !== 32'h11) begin bad++; $display("FAIL lw_rd1e got=%h exp=%h", RD1E, 32'h11); end
    // load-use stall
    StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    InstrF = 32'hAAAA_0000; PCNextF = 32'h48; PCPlus4F = 32'h4C;
    tick();
    total++; if (PCF !== 32'h44) begin bad++; $display("FAIL lu_pcf got=%h exp=%h", PCF, 32'h44); end
    total++; if (InstrD !== 32'h8C08_0004) begin bad++; $display("FAIL lu_instrd got=%h exp=%h", InstrD, 32'h8C08_0004); end
    total++; if (CtrlE !== 10'h000) begin bad++; $display("FAIL lu_ctrle got=%h exp=0", CtrlE); end
    total++; if (ValidE !== 1'b0) begin bad++; $display("FAIL lu_valide got=%b exp=0", ValidE); end
    total++; if (RD1E !== 32'h0) begin bad++; $display("FAIL lu_rd1e got=%h exp=0", RD1E); end
    total++; if (StallCount !== 16'd1) begin bad++; $display("FAIL lu_stallcnt got=%0d exp=1", StallCount); end
    total++; if (BubbleCount !== 16'd1) begin bad++; $display("FAIL lu_bubblecnt got=%0d exp=1", BubbleCount); end
    StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    tick();
    total++; if (InstrD !== 32'hAAAA_0000) begin bad++; $display("FAIL lu_resume_instrd got=%h exp=%h", InstrD, 32'hAAAA_0000); end
    total++; if (PCF !== 32'h48) begin bad++; $display("FAIL lu_resume_pcf got=%h exp=%h", PCF, 32'h48); end
    total++; if (ValidE !== 1'b1) begin bad++; $display("FAIL lu_resume_valide got=%b exp=1", ValidE); end
    $display("test_load_use: InstrD=%h StallCount=%0d BubbleCount=%0d", InstrD, StallCount, BubbleCount);
  endtask

  task automatic test_branch_clear();
    PCSrcD = 1'b1;
    tick();
    total++; if (InstrD !== 32'h0) begin bad++; $display("FAIL br_instrd got=%h exp=0", InstrD); end
    total++; if (PCPlus4D !== 32'h0) begin bad++; $display("FAIL br_pcplus4d got=%h exp=0", PCPlus4D); end
    total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL br_validd got=%b exp=0", ValidD); end
    PCSrcD = 1'b0; InstrF = 32'h1234_5678;
    tick();
    total++; if (InstrD !== 32'h1234_5678) begin bad++; $display("FAIL br_reload_instrd got=%h exp=%h", InstrD, 32'h1234_5678); end
    total++; if (ValidE !== 1'b0) begin bad++; $display("FAIL br_bubble_valide got=%b exp=0", ValidE); end
    PCSrcD = 1'b1; StallD = 1'b1; InstrF = 32'h5555_5555;
    tick();
    total++; if (InstrD !== 32'h1234_5678) begin bad++; $display("FAIL br_stall_instrd got=%h exp=%h", InstrD, 32'h1234_5678); end
    total++; if (ValidD !== 1'b1) begin bad++; $display("FAIL br_stall_validd got=%b exp=1", ValidD); end
    total++; if (StallCount !== 16'd2) begin bad++; $display("FAIL br_stallcnt got=%0d exp=2", StallCount); end
    PCSrcD = 1'b0; StallD = 1'b0;
    tick();
    $display("test_branch_clear: InstrD=%h ValidD=%b", InstrD, ValidD);
  endtask

  task automatic test_independent();
    StallF = 1'b1; StallD = 1'b0; PCNextF = 32'h100; InstrF = 32'hCAFE_0001;
    tick();
    total++; if (PCF !== 32'h48) begin bad++; $display("FAIL indF_pcf got=%h exp=%h", PCF, 32'h48); end
    total++; if (InstrD !== 32'hCAFE_0001) begin bad++; $display("FAIL indF_instrd got=%h exp=%h", InstrD, 32'hCAFE_0001); end
    StallF = 1'b0; StallD = 1'b1; PCNextF = 32'h104; InstrF = 32'hBEEF_0002;
    tick();
    total++; if (PCF !== 32'h104) begin bad++; $display("FAIL indD_pcf got=%h exp=%h", PCF, 32'h104); end
    total++; if (InstrD !== 32'hCAFE_0001) begin bad++; $display("FAIL indD_instrd got=%h exp=%h", InstrD, 32'hCAFE_0001); end
    StallD = 1'b0;
    tick();
    $display("test_independent: PCF=%h InstrD=%h", PCF, InstrD);
  endtask

  task automatic test_timeout();
    StallD = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (StallTimeout !== 1'b0) begin bad++; $display("FAIL to_early_%0d got=%b exp=0", i, StallTimeout); end
    end
    tick();
    total++; if (StallTimeout !== 1'b1) begin bad++; $display("FAIL to_fourth got=%b exp=1", StallTimeout); end
    total++; if (StallCount !== 16'd7) begin bad++; $display("FAIL to_stallcnt got=%0d exp=7", StallCount); end
    StallD = 1'b0; InstrF = 32'h0F0F_0F0F;
    tick();
    total++; if (StallTimeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", StallTimeout); end
    total++; if (InstrD !== 32'h0F0F_0F0F) begin bad++; $display("FAIL to_locked_instrd got=%h exp=%h", InstrD, 32'h0F0F_0F0F); end
    tick(); tick();
    total++; if (StallTimeout !== 1'b1) begin bad++; $display("FAIL to_sticky_late got=%b exp=1", StallTimeout); end
    reset = 1'b1;
    tick();
    total++; if (StallTimeout !== 1'b0) begin bad++; $display("FAIL to_reset got=%b exp=0", StallTimeout); end
    reset = 1'b0;
    $display("test_timeout: StallTimeout=%b", StallTimeout);
  endtask

  task automatic test_saturation();
    InstrF = 32'h2222_2222;
    tick();  // IF/ID now holds a valid instruction
    StallD = 1'b1; FlushE = 1'b1; PCNextF = 32'h200;
    repeat (65534) @(posedge clk);
    #1;
    total++; if (StallCount !== 16'hFFFE) begin bad++; $display("FAIL sat_pre_stall got=%h exp=FFFE", StallCount); end
    total++; if (BubbleCount !== 16'hFFFE) begin bad++; $display("FAIL sat_pre_bubble got=%h exp=FFFE", BubbleCount); end
    repeat (70000 - 65534) @(posedge clk);
    #1;
    total++; if (StallCount !== 16'hFFFF) begin bad++; $display("FAIL sat_stall got=%h exp=FFFF", StallCount); end
    total++; if (BubbleCount !== 16'hFFFF) begin bad++; $display("FAIL sat_bubble got=%h exp=FFFF", BubbleCount); end
    FlushE = 1'b0;
    $display("test_saturation: StallCount=%h BubbleCount=%h", StallCount, BubbleCount);
  endtask

  task automatic test_reset_mid_stall();
    StallF = 1'b1; StallD = 1'b1; PCNextF = 32'h77; reset = 1'b1;
    tick();
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL rms_pcf got=%h exp=0", PCF); end
    total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL rms_validd got=%b exp=0", ValidD); end
    total++; if (StallCount !== 16'h0) begin bad++; $display("FAIL rms_stallcnt got=%h exp=0", StallCount); end
    total++; if (StallTimeout !== 1'b0) begin bad++; $display("FAIL rms_timeout got=%b exp=0", StallTimeout); end
    reset = 1'b0; StallF = 1'b0; StallD = 1'b0;
    tick();
    total++; if (PCF !== 32'h77) begin bad++; $display("FAIL rms_release_pcf got=%h exp=%h", PCF, 32'h77); end
    $display("test_reset_mid_stall: PCF=%h ValidD=%b", PCF, ValidD);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_clear();
    test_independent();
    test_timeout();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
